// File: rtl/control_unit.sv
// Moore-style sequencer for the Mini SRC datapath: fetch, decode ir[31:27], and issue one
// micro-step of control strobes per clock. All strobes decode from the state register and ir,
// except T6 of a branch, where pc_enable and zlo_out are also gated by con_out.
module control_unit #(
  parameter bit         HALT_ON_ILLEGAL = 1'b1,
  parameter logic [4:0] ADD_CODE        = 5'b00011,
  parameter logic [4:0] AND_CODE        = 5'b00101,
  parameter logic [4:0] OR_CODE         = 5'b00110
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] ir,
  input  logic        con_out,
  input  logic        stop,
  output logic        run,
  output logic [4:0]  alu_op,
  output logic        pc_out,
  output logic        zlo_out,
  output logic        hi_out,
  output logic        lo_out,
  output logic        mdr_out,
  output logic        inport_out,
  output logic        c_sign_extended_out,
  output logic        ba_out,
  output logic        r_out,
  output logic        pc_enable,
  output logic        mar_enable,
  output logic        mdr_enable,
  output logic        ir_enable,
  output logic        y_enable,
  output logic        z_enable,
  output logic        r_in,
  output logic        con_enable,
  output logic        outport_enable,
  output logic        pc_increment,
  output logic        read,
  output logic        ram_write,
  output logic        gra,
  output logic        grb,
  output logic        grc
);

  localparam logic [4:0] OpLd   = 5'b00000;
  localparam logic [4:0] OpLdi  = 5'b00001;
  localparam logic [4:0] OpSt   = 5'b00010;
  localparam logic [4:0] OpAddi = 5'b01100;
  localparam logic [4:0] OpAndi = 5'b01101;
  localparam logic [4:0] OpOri  = 5'b01110;
  localparam logic [4:0] OpBr   = 5'b10010;
  localparam logic [4:0] OpJr   = 5'b10011;
  localparam logic [4:0] OpIn   = 5'b10110;
  localparam logic [4:0] OpOut  = 5'b10111;
  localparam logic [4:0] OpMfhi = 5'b11000;
  localparam logic [4:0] OpMflo = 5'b11001;
  localparam logic [4:0] OpNop  = 5'b11010;
  localparam logic [4:0] OpHalt = 5'b11011;

  typedef enum logic [3:0] {
    StReset, StT0, StT1, StT2, StT3, StT4, StT5, StT6, StT7, StHalt
  } state_e;

  state_e state_q, state_d;
  logic   stop_q, stop_d;

  logic [4:0] opcode;
  logic       unused_ir;
  assign opcode    = ir[31:27];
  assign unused_ir = ^ir[26:0];

  // Opcode class decode
  logic is_alu, is_imm, is_ldi, is_ld, is_st, is_br, is_jr, is_in, is_out;
  logic is_mfhi, is_mflo, is_nop, is_halt, is_illegal, is_short;
  logic [4:0] imm_code;

  always_comb begin
    is_alu     = (opcode >= 5'b00011) && (opcode <= 5'b00110);
    is_imm     = (opcode == OpAddi) || (opcode == OpAndi) || (opcode == OpOri);
    is_ldi     = (opcode == OpLdi);
    is_ld      = (opcode == OpLd);
    is_st      = (opcode == OpSt);
    is_br      = (opcode == OpBr);
    is_jr      = (opcode == OpJr);
    is_in      = (opcode == OpIn);
    is_out     = (opcode == OpOut);
    is_mfhi    = (opcode == OpMfhi);
    is_mflo    = (opcode == OpMflo);
    is_nop     = (opcode == OpNop);
    is_halt    = (opcode == OpHalt);
    is_illegal = !(is_alu || is_imm || is_ldi || is_ld || is_st || is_br || is_jr || is_in ||
                   is_out || is_mfhi || is_mflo || is_nop || is_halt);
    // Single-step instructions finish in T3; illegal ones do too when treated as nop
    is_short   = is_jr || is_in || is_out || is_mfhi || is_mflo || is_nop ||
                 (is_illegal && !HALT_ON_ILLEGAL);
    imm_code   = ADD_CODE;
    if (opcode == OpAndi) imm_code = AND_CODE;
    if (opcode == OpOri)  imm_code = OR_CODE;
  end

  // State and sticky stop request; clr aborts asynchronously
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= StReset;
      stop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      stop_q  <= stop_d;
    end
  end

  // Next-state: the last step of an instruction returns to T0 unless stop was seen
  always_comb begin
    state_e end_st;
    end_st  = (stop_q || stop) ? StHalt : StT0;
    state_d = state_q;
    case (state_q)
      StReset: state_d = StT0;
      StT0:    state_d = StT1;
      StT1:    state_d = StT2;
      StT2:    state_d = StT3;
      StT3: begin
        if (is_halt || (is_illegal && HALT_ON_ILLEGAL)) state_d = StHalt;
        else if (is_short)                              state_d = end_st;
        else                                            state_d = StT4;
      end
      StT4:    state_d = StT5;
      StT5:    state_d = (is_ld || is_st || is_br) ? StT6 : end_st;
      StT6:    state_d = (is_ld || is_st) ? StT7 : end_st;
      StT7:    state_d = end_st;
      StHalt:  state_d = StHalt;
      default: state_d = StReset;
    endcase
    stop_d = (state_d == StT0) ? 1'b0 : (stop_q || stop);
  end

  // Control strobes for the current micro-step
  always_comb begin
    run                 = (state_q != StReset) && (state_q != StHalt);
    alu_op              = 5'b00000;
    pc_out              = 1'b0;
    zlo_out             = 1'b0;
    hi_out              = 1'b0;
    lo_out              = 1'b0;
    mdr_out             = 1'b0;
    inport_out          = 1'b0;
    c_sign_extended_out = 1'b0;
    ba_out              = 1'b0;
    r_out               = 1'b0;
    pc_enable           = 1'b0;
    mar_enable          = 1'b0;
    mdr_enable          = 1'b0;
    ir_enable           = 1'b0;
    y_enable            = 1'b0;
    z_enable            = 1'b0;
    r_in                = 1'b0;
    con_enable          = 1'b0;
    outport_enable      = 1'b0;
    pc_increment        = 1'b0;
    read                = 1'b0;
    ram_write           = 1'b0;
    gra                 = 1'b0;
    grb                 = 1'b0;
    grc                 = 1'b0;
    case (state_q)
      StT0: begin
        pc_out = 1'b1; mar_enable = 1'b1; pc_increment = 1'b1; z_enable = 1'b1;
      end
      StT1: begin
        zlo_out = 1'b1; pc_enable = 1'b1; read = 1'b1; mdr_enable = 1'b1;
      end
      StT2: begin
        mdr_out = 1'b1; ir_enable = 1'b1;
      end
      StT3: begin
        if (is_alu || is_imm) begin
          grb = 1'b1; r_out = 1'b1; y_enable = 1'b1;
        end else if (is_ldi || is_ld || is_st) begin
          grb = 1'b1; ba_out = 1'b1; y_enable = 1'b1;
        end else if (is_br) begin
          gra = 1'b1; r_out = 1'b1; con_enable = 1'b1;
        end else if (is_jr) begin
          gra = 1'b1; r_out = 1'b1; pc_enable = 1'b1;
        end else if (is_in) begin
          inport_out = 1'b1; gra = 1'b1; r_in = 1'b1;
        end else if (is_out) begin
          gra = 1'b1; r_out = 1'b1; outport_enable = 1'b1;
        end else if (is_mfhi) begin
          hi_out = 1'b1; gra = 1'b1; r_in = 1'b1;
        end else if (is_mflo) begin
          lo_out = 1'b1; gra = 1'b1; r_in = 1'b1;
        end
      end
      StT4: begin
        if (is_alu) begin
          grc = 1'b1; r_out = 1'b1; z_enable = 1'b1; alu_op = opcode;
        end else if (is_imm) begin
          c_sign_extended_out = 1'b1; z_enable = 1'b1; alu_op = imm_code;
        end else if (is_ldi || is_ld || is_st) begin
          c_sign_extended_out = 1'b1; z_enable = 1'b1; alu_op = ADD_CODE;
        end else if (is_br) begin
          pc_out = 1'b1; y_enable = 1'b1;
        end
      end
      StT5: begin
        if (is_alu || is_imm || is_ldi) begin
          zlo_out = 1'b1; gra = 1'b1; r_in = 1'b1;
        end else if (is_ld || is_st) begin
          zlo_out = 1'b1; mar_enable = 1'b1;
        end else if (is_br) begin
          c_sign_extended_out = 1'b1; z_enable = 1'b1; alu_op = ADD_CODE;
        end
      end
      StT6: begin
        if (is_ld) begin
          read = 1'b1; mdr_enable = 1'b1;
        end else if (is_st) begin
          gra = 1'b1; r_out = 1'b1; mdr_enable = 1'b1;
        end else if (is_br && con_out) begin
          zlo_out = 1'b1; pc_enable = 1'b1;
        end
      end
      StT7: begin
        if (is_ld) begin
          mdr_out = 1'b1; gra = 1'b1; r_in = 1'b1;
        end else if (is_st) begin
          ram_write = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule
